// File: rtl/ift_run_scheduler.sv
// rtl/ift_run_scheduler.sv - run-level sequencer for the sector controller
// Launches a run on host go, tracks sector events, detects convergence/limit/stall, returns controller to START.
module ift_run_scheduler #(
  parameter int STATUS_BITS = 6,
  parameter int WD_BITS     = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        AVL_write_i,
  input  logic        AVL_address_i,
  input  logic [31:0] AVL_writedata_i,
  output logic [31:0] AVL_readdata_o,
  input  logic [31:0] SC_status_i,
  output logic [3:0]  cmd_reg_o,
  output logic        type_reg_o,
  output logic        busy_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, HALT} state_t;

  localparam logic [WD_BITS-1:0] WD_ONE = {{(WD_BITS-1){1'b0}}, 1'b1};

  state_t                 state, state_nx;
  logic [2:0]             st_q, st_qq;
  logic [STATUS_BITS-1:0] cnt_q;
  logic [15:0]            sector_events, max_sectors, ev_inc;
  logic [WD_BITS-1:0]     wd_cnt;
  logic [2:0]             cmd_cfg;
  logic                   type_q;
  logic                   done, aborted, timed_out, limit_hit, irq;
  logic                   host_wr, wr_go, wr_abort, wr_irq_clear;
  logic                   active, run_event, converged, limit_reached, wd_expired;
  logic                   set_abort, set_limit, set_timeout, set_done;
  logic                   unused_bits;

  assign host_wr      = AVL_write_i & AVL_address_i;
  assign wr_go        = host_wr & AVL_writedata_i[0] & ~AVL_writedata_i[5];
  assign wr_abort     = host_wr & AVL_writedata_i[5];
  assign wr_irq_clear = host_wr & AVL_writedata_i[6];

  assign active        = (state == LAUNCH) || (state == RUN);
  assign run_event     = (state == RUN) && (st_q == 3'd7) && (st_qq != 3'd7);
  assign converged     = (st_q == 3'd7) && (st_qq == 3'd7) && (cnt_q == '0);
  assign ev_inc        = (sector_events == 16'hFFFF) ? sector_events : sector_events + 16'd1;
  assign limit_reached = run_event && (max_sectors != 16'd0) && (ev_inc == max_sectors);
  assign wd_expired    = &wd_cnt;

  assign cmd_reg_o  = {cmd_cfg, active};
  assign type_reg_o = type_q;
  assign busy_o     = (state != IDLE);
  assign irq_o      = irq;

  assign unused_bits = ^{AVL_writedata_i[31:24], AVL_writedata_i[7], SC_status_i[31:STATUS_BITS+3]};

  always_comb begin
    state_nx    = state;
    set_abort   = 1'b0;
    set_limit   = 1'b0;
    set_timeout = 1'b0;
    set_done    = 1'b0;
    case (state)
      IDLE: if (wr_go) state_nx = LAUNCH;
      LAUNCH, RUN: begin
        if (wr_abort) begin
          set_abort = 1'b1;
          state_nx  = HALT;
        end else if (state == RUN && (converged || limit_reached)) begin
          set_limit = limit_reached;
          state_nx  = HALT;
        end else if (wd_expired && !run_event) begin
          // a stall only counts when this cycle brought no sector event
          set_timeout = 1'b1;
          state_nx    = HALT;
        end else if (state == LAUNCH && st_q != 3'd0) begin
          state_nx = RUN;
        end
      end
      HALT: begin
        if (st_q == 3'd0) begin
          set_done = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= IDLE;
      st_q           <= 3'd0;
      st_qq          <= 3'd0;
      cnt_q          <= '0;
      sector_events  <= 16'd0;
      max_sectors    <= 16'd0;
      wd_cnt         <= '0;
      cmd_cfg        <= 3'd0;
      type_q         <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      timed_out      <= 1'b0;
      limit_hit      <= 1'b0;
      irq            <= 1'b0;
      AVL_readdata_o <= 32'd0;
    end else begin
      state          <= state_nx;
      st_q           <= SC_status_i[2:0];
      st_qq          <= st_q;
      cnt_q          <= SC_status_i[STATUS_BITS+2:3];
      AVL_readdata_o <= {8'd0, sector_events, st_q, limit_hit, timed_out, aborted, done, busy_o};
      if (state == IDLE && wr_go) begin
        cmd_cfg       <= AVL_writedata_i[3:1];
        type_q        <= AVL_writedata_i[4];
        max_sectors   <= AVL_writedata_i[23:8];
        sector_events <= 16'd0;
        wd_cnt        <= '0;
        done          <= 1'b0;
        aborted       <= 1'b0;
        timed_out     <= 1'b0;
        limit_hit     <= 1'b0;
        irq           <= 1'b0;
      end else begin
        if (wr_irq_clear) irq <= 1'b0;
        if (active) wd_cnt <= run_event ? '0 : (wd_expired ? wd_cnt : wd_cnt + WD_ONE);
        if (run_event) sector_events <= ev_inc;
        if (set_abort) aborted <= 1'b1;
        if (set_limit) limit_hit <= 1'b1;
        if (set_timeout) timed_out <= 1'b1;
        if (set_done) begin
          done <= 1'b1;
          irq  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ift_run_scheduler.sv
// tb/tb_ift_run_scheduler.sv - directed self-checking bench for ift_run_scheduler
// Includes a small sector-controller model (START->READ->...->WAIT) driving SC_status_i.
module tb_ift_run_scheduler;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        AVL_write_i = 1'b0;
  logic        AVL_address_i = 1'b0;
  logic [31:0] AVL_writedata_i = 32'd0;
  logic [31:0] AVL_readdata_o;
  logic [31:0] SC_status_i;
  logic [3:0]  cmd_reg_o;
  logic        type_reg_o;
  logic        busy_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  int mode = 0;  // 0 converging, 1 never converging, 2 stuck outside WAIT

  logic [2:0] m_st;
  logic [5:0] m_cnt;

  always #5 clock_i = ~clock_i;

  ift_run_scheduler #(.STATUS_BITS(6), .WD_BITS(4)) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .AVL_write_i     (AVL_write_i),
    .AVL_address_i   (AVL_address_i),
    .AVL_writedata_i (AVL_writedata_i),
    .AVL_readdata_o  (AVL_readdata_o),
    .SC_status_i     (SC_status_i),
    .cmd_reg_o       (cmd_reg_o),
    .type_reg_o      (type_reg_o),
    .busy_o          (busy_o),
    .irq_o           (irq_o)
  );

  // Controller model: state register, then a registered readdata word.
  always @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      m_st        <= 3'd0;
      m_cnt       <= 6'd0;
      SC_status_i <= 32'd0;
    end else begin
      SC_status_i <= {23'd0, m_cnt, m_st};
      if (!cmd_reg_o[0]) begin
        m_st  <= 3'd0;
        m_cnt <= (mode == 0) ? 6'd19 : 6'd9;
      end else begin
        case (m_st)
          3'd0: m_st <= 3'd1;
          3'd1: m_st <= (mode == 2) ? 3'd3 : 3'd2;
          3'd2: m_st <= 3'd7;
          3'd7: if (m_cnt != 6'd0) begin
            m_st <= 3'd1;
            if (mode == 0) m_cnt <= m_cnt - 6'd1;
          end
          default: m_st <= m_st;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is sampled on the following posedge.
  task automatic host_write(input logic addr, input logic [31:0] data);
    AVL_write_i = 1'b1;
    AVL_address_i = addr;
    AVL_writedata_i = data;
    @(negedge clock_i);
    AVL_write_i = 1'b0;
    AVL_address_i = 1'b0;
    AVL_writedata_i = 32'd0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 400) begin
      @(negedge clock_i);
      n++;
    end
    check(tag, 32'(busy_o), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock_i);
    check("reset_cmd", 32'(cmd_reg_o), 32'd0);
    check("reset_type", 32'(type_reg_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_irq", 32'(irq_o), 32'd0);
    check("reset_rdata", AVL_readdata_o, 32'd0);
    reset_i = 1'b0;
    @(negedge clock_i);

    host_write(1'b0, 32'h0000_0001);
    check("addr0_ignored", 32'(busy_o), 32'd0);

    // Convergence after 20 sector events
    mode = 0;
    @(negedge clock_i);
    host_write(1'b1, 32'h0000_0001);
    check("conv_busy", 32'(busy_o), 32'd1);
    check("conv_cmd", 32'(cmd_reg_o), 32'h1);
    begin
      int n = 0;
      while (!(SC_status_i[2:0] == 3'd7 && SC_status_i[8:3] == 6'd0) && n < 500) begin
        @(negedge clock_i);
        n++;
      end
      check("conv_seen", 32'(n < 500), 32'd1);
    end
    @(negedge clock_i);
    @(negedge clock_i);
    check("conv_cmd_hold", 32'(cmd_reg_o[0]), 32'd1);
    @(negedge clock_i);
    check("conv_cmd_drop", 32'(cmd_reg_o[0]), 32'd0);
    check("conv_irq_halt", 32'(irq_o), 32'd0);
    wait_idle("conv_idle");
    check("conv_irq", 32'(irq_o), 32'd1);
    @(negedge clock_i);
    check("conv_rdata", AVL_readdata_o, 32'h0000_1402);

    // Sector limit of 5, never converging
    mode = 1;
    @(negedge clock_i);
    host_write(1'b1, 32'h0000_0501);
    check("lim_irq_cleared", 32'(irq_o), 32'd0);
    wait_idle("lim_idle");
    check("lim_irq", 32'(irq_o), 32'd1);
    @(negedge clock_i);
    check("lim_rdata", AVL_readdata_o, 32'h0000_0512);

    host_write(1'b1, 32'h0000_0040);
    check("irqclr_irq", 32'(irq_o), 32'd0);
    @(negedge clock_i);
    check("irqclr_done_kept", AVL_readdata_o, 32'h0000_0512);

    // Abort mid-run, with non-zero config latched
    host_write(1'b1, 32'h0000_001D);
    check("abort_cmd_run", 32'(cmd_reg_o), 32'hD);
    check("abort_type", 32'(type_reg_o), 32'd1);
    repeat (15) @(negedge clock_i);
    host_write(1'b1, 32'h0000_0020);
    check("abort_irq_halt", 32'(irq_o), 32'd0);
    @(negedge clock_i);
    check("abort_cmd_drop", 32'(cmd_reg_o), 32'hC);
    wait_idle("abort_idle");
    check("abort_irq", 32'(irq_o), 32'd1);
    @(negedge clock_i);
    check("abort_flags", 32'(AVL_readdata_o[7:0]), 32'h06);
    check("abort_cfg_hold", 32'({type_reg_o, cmd_reg_o}), 32'h1C);

    // Watchdog: controller never reaches WAIT
    mode = 2;
    @(negedge clock_i);
    host_write(1'b1, 32'h0000_0001);
    repeat (15) @(negedge clock_i);
    check("wd_cmd_hold", 32'(cmd_reg_o[0]), 32'd1);
    @(negedge clock_i);
    check("wd_cmd_drop", 32'(cmd_reg_o[0]), 32'd0);
    wait_idle("wd_idle");
    check("wd_irq", 32'(irq_o), 32'd1);
    @(negedge clock_i);
    check("wd_rdata", AVL_readdata_o, 32'h0000_000A);

    // Go+abort together is ignored; a go while busy is ignored
    mode = 0;
    @(negedge clock_i);
    host_write(1'b1, 32'h0000_0021);
    check("goabort_busy", 32'(busy_o), 32'd0);
    check("goabort_cmd", 32'(cmd_reg_o[0]), 32'd0);
    @(negedge clock_i);
    check("goabort_rdata", AVL_readdata_o, 32'h0000_000A);
    host_write(1'b1, 32'h0000_0001);
    repeat (20) @(negedge clock_i);
    host_write(1'b1, 32'h0000_0201);
    check("gobusy_busy", 32'(busy_o), 32'd1);
    wait_idle("gobusy_idle");
    @(negedge clock_i);
    check("gobusy_rdata", AVL_readdata_o, 32'h0000_1402);

    // Asynchronous reset mid-run, then a clean run
    host_write(1'b1, 32'h0000_001F);
    check("rst_cmd_run", 32'(cmd_reg_o), 32'hF);
    repeat (10) @(negedge clock_i);
    #1 reset_i = 1'b1;
    #1;
    check("rst_cmd", 32'(cmd_reg_o), 32'd0);
    check("rst_type", 32'(type_reg_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_rdata", AVL_readdata_o, 32'd0);
    @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
    host_write(1'b1, 32'h0000_0001);
    check("post_rst_busy", 32'(busy_o), 32'd1);
    wait_idle("post_rst_idle");
    check("post_rst_irq", 32'(irq_o), 32'd1);
    @(negedge clock_i);
    check("post_rst_rdata", AVL_readdata_o, 32'h0000_1402);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
